ex_md: RTL and testbench

Execute stage with integrated iterative multiply/divide unit for the RV32IM pipeline, placed between the ID/EX and EX/MEM pipeline registers. It keeps the existing single-cycle ALU, branch-target and operand-forwarding datapath. It adds a full 4-way forwarding select and a multi-cycle M-extension engine covering MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. While that engine is busy it stalls the front of the pipeline.

---
 rtl/ex_md.sv | 180 ++++++++++++++++++
 tb/tb_ex_md.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ex_md.sv
// ex_md: RV32IM execute stage with 4-way forwarding, single-cycle ALU and an iterative mul/div engine
package riscv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;
    typedef struct packed {
        logic    alu_src;
        alu_op_t alu_op;
    } riscv_control_t;
endpackage

module ex_md
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic                 flush_in,
    input  logic [1:0]           rs1_src_in,
    input  logic [1:0]           rs2_src_in,
    input  logic [WIDTH-1:0]     pc_in,
    input  logic [WIDTH-1:0]     rs1_in,
    input  logic [WIDTH-1:0]     rs2_in,
    input  logic [WIDTH-1:0]     signimm_in,
    input  logic [WIDTH-1:0]     wb_data_to_write_in,
    input  logic [WIDTH-1:0]     exmem_alu_res_in,
    input  logic [WIDTH-1:0]     memwb_res_in,
    input  riscv_control_t       ctrl_vector_in,
    input  logic                 md_en_in,
    input  logic [2:0]           md_op_in,
    output logic                 stall_out,
    output logic                 zero_out,
    output logic [WIDTH-1:0]     pc_branch_out,
    output logic [WIDTH-1:0]     drs2_fw_out,
    output logic [WIDTH-1:0]     alu_res_out
);
    localparam int SH_W = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_nx, prod_fx;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, res_q, res_d, opa_q, opa_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0]   rs1_fw, rs2_fw, opb, alu_res, a_mag, b_mag;
    logic [WIDTH-1:0]   quo_nx, rem_nx, quo_fx, rem_fx;
    logic [WIDTH:0]     acc, r_sh, diff;
    logic               start, last, a_neg, b_neg, div_zero, div_ovf;

    assign rs1_fw = rs1_src_in[1] ? (rs1_src_in[0] ? memwb_res_in : exmem_alu_res_in)
                                  : (rs1_src_in[0] ? wb_data_to_write_in : rs1_in);
    assign rs2_fw = rs2_src_in[1] ? (rs2_src_in[0] ? memwb_res_in : exmem_alu_res_in)
                                  : (rs2_src_in[0] ? wb_data_to_write_in : rs2_in);
    assign opb = ctrl_vector_in.alu_src ? signimm_in : rs2_fw;

    always_comb begin
        case (ctrl_vector_in.alu_op)
            ALU_ADD:  alu_res = rs1_fw + opb;
            ALU_SUB:  alu_res = rs1_fw - opb;
            ALU_SLL:  alu_res = rs1_fw << opb[SH_W-1:0];
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(rs1_fw) < $signed(opb)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, rs1_fw < opb};
            ALU_XOR:  alu_res = rs1_fw ^ opb;
            ALU_SRL:  alu_res = rs1_fw >> opb[SH_W-1:0];
            ALU_SRA:  alu_res = $unsigned($signed(rs1_fw) >>> opb[SH_W-1:0]);
            ALU_OR:   alu_res = rs1_fw | opb;
            ALU_AND:  alu_res = rs1_fw & opb;
            default:  alu_res = '0;
        endcase
    end

    assign start    = valid_in & md_en_in & !flush_in;
    assign a_neg    = rs1_fw[WIDTH-1] & (~md_op_in[0] | (md_op_in == 3'd1));
    assign b_neg    = rs2_fw[WIDTH-1] & ((~md_op_in[0] & (md_op_in != 3'd2)) | (md_op_in == 3'd1));
    assign a_mag    = a_neg ? -rs1_fw : rs1_fw;
    assign b_mag    = b_neg ? -rs2_fw : rs2_fw;
    assign div_zero = md_op_in[2] & (rs2_fw == '0);
    assign div_ovf  = md_op_in[2] & ~md_op_in[0] & (rs1_fw == {1'b1, {(WIDTH-1){1'b0}}}) & (&rs2_fw);

    // multiplier bits sit in the low half of prod_q and shift out as the sum shifts in
    assign acc     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
    assign prod_nx = {acc, prod_q[WIDTH-1:1]};
    assign r_sh    = {rem_q, quo_q[WIDTH-1]};
    assign diff    = r_sh - {1'b0, opa_q};
    assign rem_nx  = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign prod_fx = neg_q ? -prod_nx : prod_nx;
    assign quo_fx  = neg_q ? -quo_nx : quo_nx;
    assign rem_fx  = rneg_q ? -rem_nx : rem_nx;
    assign last    = cnt_q == CNT_W'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        res_d   = res_q;
        opa_d   = opa_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        case (state_q)
            S_IDLE: if (start) begin
                op_d    = md_op_in;
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                opa_d   = b_mag;
                prod_d  = {{WIDTH{1'b0}}, a_mag};
                quo_d   = a_mag;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = md_op_in[2] ? S_DIV : S_MUL;
                if (div_zero) begin
                    res_d   = md_op_in[1] ? rs1_fw : '1;
                    state_d = S_DONE;
                end else if (div_ovf) begin
                    res_d   = md_op_in[1] ? '0 : rs1_fw;
                    state_d = S_DONE;
                end
            end
            S_MUL: begin
                prod_d = prod_nx;
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    res_d   = (op_q == 3'd0) ? prod_fx[WIDTH-1:0] : prod_fx[2*WIDTH-1:WIDTH];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    res_d   = op_q[1] ? rem_fx : quo_fx;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_in) state_d = S_IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            opa_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            opa_q   <= opa_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign stall_out     = start & (state_q != S_DONE);
    assign alu_res_out   = (state_q == S_DONE) ? res_q : alu_res;
    assign zero_out      = alu_res_out == '0;
    assign pc_branch_out = pc_in + signimm_in;
    assign drs2_fw_out   = rs2_fw;
endmodule

// File: tb/tb_ex_md.sv
// tb_ex_md: directed vectors for the execute stage and its mul/div engine
module tb_ex_md;
    import riscv_pkg::*;

    logic           clk_in = 1'b0;
    logic           rst_in, valid_in, flush_in, md_en_in, stall_out, zero_out;
    logic [1:0]     rs1_src_in, rs2_src_in;
    logic [2:0]     md_op_in;
    logic [31:0]    pc_in, rs1_in, rs2_in, signimm_in, wb_data_to_write_in, exmem_alu_res_in, memwb_res_in;
    logic [31:0]    pc_branch_out, drs2_fw_out, alu_res_out;
    riscv_control_t ctrl_vector_in;
    int             checks = 0;
    int             errors = 0;

    ex_md dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .flush_in(flush_in),
        .rs1_src_in(rs1_src_in), .rs2_src_in(rs2_src_in), .pc_in(pc_in), .rs1_in(rs1_in),
        .rs2_in(rs2_in), .signimm_in(signimm_in), .wb_data_to_write_in(wb_data_to_write_in),
        .exmem_alu_res_in(exmem_alu_res_in), .memwb_res_in(memwb_res_in),
        .ctrl_vector_in(ctrl_vector_in), .md_en_in(md_en_in), .md_op_in(md_op_in),
        .stall_out(stall_out), .zero_out(zero_out), .pc_branch_out(pc_branch_out),
        .drs2_fw_out(drs2_fw_out), .alu_res_out(alu_res_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // called at posedge+1; returns at posedge+1 of the cycle after DONE
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_n);
        int n;
        n = 0;
        valid_in = 1'b1; md_en_in = 1'b1; md_op_in = op;
        rs1_in = a; rs2_in = b; rs1_src_in = 2'b00; rs2_src_in = 2'b00;
        #1;
        while (stall_out && n < 100) begin
            n++;
            @(posedge clk_in); #1;
            rs1_in = 32'hDEAD_BEEF; rs2_in = 32'h1234_5678;
            #1;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_n));
        chk(tag, alu_res_out, exp_res);
        chk({tag, "_zero"}, {31'b0, zero_out}, {31'b0, exp_res == 32'h0});
        @(posedge clk_in); #1;
    endtask

    initial begin
        rst_in = 1'b1; valid_in = 1'b0; flush_in = 1'b0; md_en_in = 1'b0; md_op_in = 3'd0;
        rs1_src_in = 2'b00; rs2_src_in = 2'b00; pc_in = 32'h0; rs1_in = 32'd3; rs2_in = 32'd4;
        signimm_in = 32'h0; wb_data_to_write_in = 32'h0; exmem_alu_res_in = 32'h0; memwb_res_in = 32'h0;
        ctrl_vector_in = '{alu_src: 1'b0, alu_op: ALU_ADD};
        @(posedge clk_in); @(posedge clk_in); #2;
        chk("rst_stall", {31'b0, stall_out}, 32'h0);
        chk("rst_alu", alu_res_out, 32'd7);
        chk("rst_state", 32'(dut.state_q), 32'h0);
        chk("rst_res", dut.res_q, 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        valid_in = 1'b1; rs1_src_in = 2'b10; exmem_alu_res_in = 32'd5; rs2_in = 32'd7;
        #1;
        chk("add_fw", alu_res_out, 32'd12);
        chk("add_stall", {31'b0, stall_out}, 32'h0);
        rs1_src_in = 2'b01; wb_data_to_write_in = 32'd20; signimm_in = 32'hFFFF_FFFC;
        ctrl_vector_in = '{alu_src: 1'b1, alu_op: ALU_SUB}; pc_in = 32'h100;
        rs2_src_in = 2'b11; memwb_res_in = 32'h55;
        #1;
        chk("sub_imm", alu_res_out, 32'd24);
        chk("pc_branch", pc_branch_out, 32'hFC);
        chk("drs2_fw", drs2_fw_out, 32'h55);
        rs1_src_in = 2'b11; ctrl_vector_in = '{alu_src: 1'b0, alu_op: ALU_SUB};
        #1;
        chk("sub_zero", {31'b0, zero_out}, 32'h1);
        @(posedge clk_in); #1;

        run_md("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_md("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
        run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_md("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_md("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_md("div_nd", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_md("rem_nd", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_md("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_md("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_md("rem_z", 3'd6, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 1);
        run_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        md_op_in = 3'd0; rs1_in = 32'd9; rs2_in = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
        end
        flush_in = 1'b1;
        #1;
        chk("flush_stall", {31'b0, stall_out}, 32'h0);
        @(posedge clk_in); #1;
        flush_in = 1'b0; md_en_in = 1'b0; ctrl_vector_in = '{alu_src: 1'b0, alu_op: ALU_ADD};
        rs1_src_in = 2'b00; rs2_src_in = 2'b00; rs1_in = 32'd1; rs2_in = 32'd2;
        #1;
        chk("flush_state", 32'(dut.state_q), 32'h0);
        chk("flush_add", alu_res_out, 32'd3);
        chk("flush_add_stall", {31'b0, stall_out}, 32'h0);
        @(posedge clk_in); #1;

        md_en_in = 1'b1; md_op_in = 3'd4; rs1_in = 32'd1000; rs2_in = 32'd3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_in); #1;
        end
        rst_in = 1'b1; valid_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        #1;
        chk("mrst_stall", {31'b0, stall_out}, 32'h0);
        chk("mrst_state", 32'(dut.state_q), 32'h0);
        chk("mrst_cnt", 32'(dut.cnt_q), 32'h0);
        chk("mrst_prod_hi", dut.prod_q[63:32], 32'h0);
        chk("mrst_prod_lo", dut.prod_q[31:0], 32'h0);
        chk("mrst_quo", dut.quo_q, 32'h0);
        chk("mrst_rem", dut.rem_q, 32'h0);
        chk("mrst_res", dut.res_q, 32'h0);
        run_md("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
